// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Reset/lock sequencer for 1..4 PLLs that share a reference clock. It pulses
// the PLL reset pins and synchronises the raw LOCK pins. It waits for all
// participating locks to stay high long enough, and retries a bounded number
// of times on timeout. It then raises a single READY that downstream domains
// use to release their resets. Runs on the PLL reference clock only.
//
// Ports
//   CLKI       in   PLL reference clock (only clock)
//   RST        in   synchronous active-high reset
//   LOCK       in   raw PLL LOCK pins, asynchronous, one per PLL
//   RETRY_REQ  in   single-cycle pulse, restarts the sequence from FAIL
//   PLL_RST    out  reset to every PLL, all bits identical
//   READY      out  all unmasked PLLs locked and stable
//   FAIL       out  retries exhausted, PLLs held in reset
//   RETRY_CNT  out  re-reset attempts used in the current sequence
//   LOSS_CNT   out  lock-loss events seen in READY, saturates at 255
//   STATE      out  encoded FSM state for debug
//
// state        | meaning
// -------------+-----------------------------------------------------------
// RST_ASSERT 0 | PLL_RST high for RST_PULSE_CYC cycles
// WAIT_LOCK  1 | PLL_RST low, timeout running, waiting for all locks
// STABLE     2 | all locks high, counting towards LOCK_STABLE_CYC
// READY      3 | locked and stable; any lock drop re-runs the sequence
// FAIL       4 | retries exhausted, PLLs held in reset until RETRY_REQ

module pll_lock_supervisor #(
  parameter int                 NUM_PLL          = 2,
  parameter logic [NUM_PLL-1:0] PLL_MASK         = {NUM_PLL{1'b1}},
  parameter int                 RST_PULSE_CYC    = 16,
  parameter int                 LOCK_STABLE_CYC  = 1024,
  parameter int                 LOCK_TIMEOUT_CYC = 100000,
  parameter int                 MAX_RETRY        = 3
) (
  input  logic               CLKI,
  input  logic               RST,
  input  logic [NUM_PLL-1:0] LOCK,
  input  logic               RETRY_REQ,
  output logic [NUM_PLL-1:0] PLL_RST,
  output logic               READY,
  output logic               FAIL,
  output logic [3:0]         RETRY_CNT,
  output logic [7:0]         LOSS_CNT,
  output logic [2:0]         STATE
);

  localparam int RPW = $clog2(RST_PULSE_CYC);
  localparam int STW = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
  localparam int TOW = $clog2(LOCK_TIMEOUT_CYC);

  localparam logic [RPW-1:0] RP_LAST   = RPW'(RST_PULSE_CYC - 1);
  localparam logic [STW-1:0] ST_LAST   = STW'(LOCK_STABLE_CYC - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [3:0]     RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST_ASSERT = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_READY      = 3'd3,
    S_FAIL       = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [NUM_PLL-1:0] lock_meta;
  logic [NUM_PLL-1:0] lock_sync;
  logic               all_lock;
  logic [RPW-1:0]     pulse_cnt;
  logic [TOW-1:0]     to_cnt;
  logic [STW-1:0]     st_cnt;
  logic [3:0]         retry_cnt;
  logic [3:0]         retry_nx;
  logic [7:0]         loss_cnt;
  logic [7:0]         loss_nx;
  logic               pll_rst_q;
  logic               ready_q;
  logic               fail_q;
  logic               pulse_done;
  logic               timed_out;
  logic               stable_done;

  // Two-flop synchroniser on the asynchronous LOCK pins.
  always_ff @(posedge CLKI) begin
    if (RST) begin
      lock_meta <= '0;
      lock_sync <= '0;
    end else begin
      lock_meta <= LOCK;
      lock_sync <= lock_meta;
    end
  end

  // Masked-out PLLs count as locked.
  assign all_lock    = &(lock_sync | ~PLL_MASK);
  assign pulse_done  = (pulse_cnt == RP_LAST);
  assign timed_out   = (to_cnt == TO_LAST);
  assign stable_done = (st_cnt == ST_LAST);

  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    loss_nx  = loss_cnt;
    case (state)
      S_RST_ASSERT: begin
        if (pulse_done) state_nx = S_WAIT_LOCK;
      end
      S_WAIT_LOCK, S_STABLE: begin
        // Timeout takes priority over a stable window completing.
        if (timed_out) begin
          if (retry_cnt < RETRY_LIM) begin
            retry_nx = retry_cnt + 4'd1;
            state_nx = S_RST_ASSERT;
          end else begin
            state_nx = S_FAIL;
          end
        end else if (state == S_WAIT_LOCK) begin
          if (all_lock) state_nx = S_STABLE;
        end else if (!all_lock) begin
          state_nx = S_WAIT_LOCK;
        end else if (stable_done) begin
          state_nx = S_READY;
        end
      end
      S_READY: begin
        if (!all_lock) begin
          state_nx = S_RST_ASSERT;
          retry_nx = '0;
          if (loss_cnt != 8'hFF) loss_nx = loss_cnt + 8'd1;
        end
      end
      S_FAIL: begin
        if (RETRY_REQ) begin
          state_nx = S_RST_ASSERT;
          retry_nx = '0;
        end
      end
      default: state_nx = S_RST_ASSERT;
    endcase
  end

  always_ff @(posedge CLKI) begin
    if (RST) begin
      state     <= S_RST_ASSERT;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pulse_cnt <= '0;
      to_cnt    <= '0;
      st_cnt    <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      retry_cnt <= retry_nx;
      loss_cnt  <= loss_nx;
      pulse_cnt <= (state == S_RST_ASSERT && state_nx == S_RST_ASSERT)
                   ? pulse_cnt + RPW'(1) : '0;
      // The timeout window starts on leaving RST_ASSERT and spans any
      // bouncing between WAIT_LOCK and STABLE.
      to_cnt    <= ((state == S_WAIT_LOCK || state == S_STABLE) &&
                    (state_nx == S_WAIT_LOCK || state_nx == S_STABLE))
                   ? to_cnt + TOW'(1) : '0;
      st_cnt    <= (state == S_STABLE && state_nx == S_STABLE)
                   ? st_cnt + STW'(1) : '0;
      // Outputs are registered from the next state so they carry no
      // decode glitches into downstream reset logic.
      pll_rst_q <= (state_nx == S_RST_ASSERT) || (state_nx == S_FAIL);
      ready_q   <= (state_nx == S_READY);
      fail_q    <= (state_nx == S_FAIL);
    end
  end

  assign PLL_RST   = {NUM_PLL{pll_rst_q}};
  assign READY     = ready_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_cnt;
  assign LOSS_CNT  = loss_cnt;
  assign STATE     = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor. Two instances share all inputs: one
// supervises both PLLs, the other masks PLL 1 out. A behavioural model
// built around "time since PLL reset release" and "length of the current
// lock run" predicts every output each cycle. Directed checks cover the
// timing points of the sequence.

module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int SC = 8;
  localparam int TO = 32;
  localparam int MR = 2;

  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_READY = 3, P_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       retry_req;
  logic [1:0] lock;

  logic [1:0] a_pll_rst, b_pll_rst;
  logic       a_ready, b_ready, a_fail, b_fail;
  logic [3:0] a_retry, b_retry;
  logic [7:0] a_loss, b_loss;
  logic [2:0] a_state, b_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .NUM_PLL(2), .PLL_MASK(2'b11), .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(SC),
    .LOCK_TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dut_a (
    .CLKI(clk), .RST(rst), .LOCK(lock), .RETRY_REQ(retry_req),
    .PLL_RST(a_pll_rst), .READY(a_ready), .FAIL(a_fail),
    .RETRY_CNT(a_retry), .LOSS_CNT(a_loss), .STATE(a_state)
  );

  pll_lock_supervisor #(
    .NUM_PLL(2), .PLL_MASK(2'b01), .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(SC),
    .LOCK_TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dut_b (
    .CLKI(clk), .RST(rst), .LOCK(lock), .RETRY_REQ(retry_req),
    .PLL_RST(b_pll_rst), .READY(b_ready), .FAIL(b_fail),
    .RETRY_CNT(b_retry), .LOSS_CNT(b_loss), .STATE(b_state)
  );

  // Reference model
  int         m_phase   [2];
  int         m_pulse   [2];  // reset-pulse cycles already spent
  int         m_elapsed [2];  // cycles since PLL reset release
  int         m_run     [2];  // length of the current all-locked run
  int         m_retries [2];
  int         m_loss    [2];
  logic [1:0] raw_d1 = 2'b00; // raw LOCK seen one edge ago
  logic [1:0] raw_d2 = 2'b00; // raw LOCK seen two edges ago

  task automatic restart_pulse(input int d);
    m_phase[d] = P_RST;
    m_pulse[d] = 0;
  endtask

  task automatic model_edge();
    logic [1:0] mask;
    bit         locked;
    for (int d = 0; d < 2; d++) begin
      mask   = (d == 0) ? 2'b11 : 2'b01;
      locked = &(raw_d2 | ~mask);
      if (rst) begin
        m_phase[d] = P_RST; m_pulse[d] = 0; m_elapsed[d] = 0;
        m_run[d] = 0; m_retries[d] = 0; m_loss[d] = 0;
      end else if (m_phase[d] == P_RST) begin
        if (m_pulse[d] == RP - 1) begin
          m_phase[d]   = P_WAIT;
          m_elapsed[d] = 0;
        end else begin
          m_pulse[d]++;
        end
      end else if (m_phase[d] == P_WAIT || m_phase[d] == P_STABLE) begin
        if (m_elapsed[d] == TO - 1) begin
          if (m_retries[d] < MR) begin
            m_retries[d]++;
            restart_pulse(d);
          end else begin
            m_phase[d] = P_FAIL;
          end
        end else begin
          m_elapsed[d]++;
          if (!locked) begin
            m_phase[d] = P_WAIT;
            m_run[d]   = 0;
          end else if (m_phase[d] == P_WAIT) begin
            m_phase[d] = P_STABLE;
            m_run[d]   = 0;
          end else if (m_run[d] == SC - 1) begin
            m_phase[d] = P_READY;
          end else begin
            m_run[d]++;
          end
        end
      end else if (m_phase[d] == P_READY) begin
        if (!locked) begin
          m_loss[d]    = (m_loss[d] >= 255) ? 255 : m_loss[d] + 1;
          m_retries[d] = 0;
          restart_pulse(d);
        end
      end else begin
        if (retry_req) begin
          m_retries[d] = 0;
          restart_pulse(d);
        end
      end
    end
    if (rst) begin
      raw_d2 = 2'b00;
      raw_d1 = 2'b00;
    end else begin
      raw_d2 = raw_d1;
      raw_d1 = lock;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [1:0] pr [2];
    logic       rd [2], fl [2];
    logic [3:0] rc [2];
    logic [7:0] lc [2];
    logic [2:0] st [2];
    pr[0] = a_pll_rst; rd[0] = a_ready; fl[0] = a_fail;
    rc[0] = a_retry;   lc[0] = a_loss;  st[0] = a_state;
    pr[1] = b_pll_rst; rd[1] = b_ready; fl[1] = b_fail;
    rc[1] = b_retry;   lc[1] = b_loss;  st[1] = b_state;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("model%0d_state", d), 32'(st[d]), 32'(m_phase[d]));
      chk($sformatf("model%0d_pll_rst", d), 32'(pr[d]),
          (m_phase[d] == P_RST || m_phase[d] == P_FAIL) ? 32'd3 : 32'd0);
      chk($sformatf("model%0d_ready", d), 32'(rd[d]), 32'(m_phase[d] == P_READY));
      chk($sformatf("model%0d_fail", d), 32'(fl[d]), 32'(m_phase[d] == P_FAIL));
      chk($sformatf("model%0d_retry_cnt", d), 32'(rc[d]), 32'(m_retries[d]));
      chk($sformatf("model%0d_loss_cnt", d), 32'(lc[d]), 32'(m_loss[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(a_state), 32'd0);
    chk({tag, "_pll_rst"}, 32'(a_pll_rst), 32'd3);
    chk({tag, "_ready"}, 32'(a_ready), 32'd0);
    chk({tag, "_fail"}, 32'(a_fail), 32'd0);
    chk({tag, "_retry_cnt"}, 32'(a_retry), 32'd0);
    chk({tag, "_loss_cnt"}, 32'(a_loss), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, cnt, falls, max_r, seg;
    logic [1:0] prev;
    bit saw_wait;

    rst = 1'b1; lock = 2'b00; retry_req = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");

    // Power-up: reset pulse length and lock-to-READY latency
    rst = 1'b0;
    cnt = 0; n = 0;
    while (a_pll_rst == 2'b11 && n < 20) begin cnt++; step(); n++; end
    chk("s1_pll_rst_len", 32'(cnt), 32'd4);
    step(); step();
    lock = 2'b11;
    n = 0;
    while (a_ready !== 1'b1 && n < 60) begin step(); n++; end
    chk("s1_ready_latency", 32'(n), 32'd11);
    chk("s1_retry_cnt", 32'(a_retry), 32'd0);
    chk("s1_state", 32'(a_state), 32'd3);

    // One-cycle glitch during STABLE
    rst = 1'b1; step(); step(); rst = 1'b0;
    n = 0;
    while (a_state !== 3'd2 && n < 30) begin step(); n++; end
    chk("s2_reach_stable", 32'(a_state), 32'd2);
    repeat (5) step();
    lock = 2'b01; step(); lock = 2'b11;
    n = 0; saw_wait = 1'b0;
    while (a_ready !== 1'b1 && n < 60) begin
      step(); n++;
      if (a_state == 3'd1) saw_wait = 1'b1;
    end
    chk("s2_saw_wait_lock", 32'(saw_wait), 32'd1);
    chk("s2_ready_latency", 32'(n), 32'd11);
    chk("s2_loss_cnt", 32'(a_loss), 32'd0);

    // No lock: initial attempt plus two retries, then FAIL and RETRY_REQ
    rst = 1'b1; lock = 2'b00; step(); step(); rst = 1'b0;
    n = 0; falls = 0; max_r = 0; prev = a_pll_rst;
    while (a_fail !== 1'b1 && n < 400) begin
      step(); n++;
      if (prev == 2'b11 && a_pll_rst == 2'b00) falls++;
      prev = a_pll_rst;
      if (int'(a_retry) > max_r) max_r = int'(a_retry);
    end
    chk("s3_cycles_to_fail", 32'(n), 32'd108);
    chk("s3_pll_rst_pulses", 32'(falls), 32'd3);
    chk("s3_max_retry_cnt", 32'(max_r), 32'd2);
    chk("s3_fail", 32'(a_fail), 32'd1);
    chk("s3_pll_rst_held", 32'(a_pll_rst), 32'd3);
    chk("s3_state", 32'(a_state), 32'd4);
    repeat (5) step();
    chk("s3_fail_sticky", 32'(a_fail), 32'd1);
    lock = 2'b11; retry_req = 1'b1; step(); retry_req = 1'b0;
    chk("s3_fail_cleared", 32'(a_fail), 32'd0);
    chk("s3_retry_cleared", 32'(a_retry), 32'd0);
    chk("s3_state_restart", 32'(a_state), 32'd0);
    n = 0;
    while (a_ready !== 1'b1 && n < 80) begin step(); n++; end
    chk("s3_ready_after_retry", 32'(n), 32'd13);

    // Lock loss in READY, LOSS_CNT saturation
    for (int i = 0; i < 260; i++) begin
      lock = 2'b01; step(); lock = 2'b11;
      n = 0;
      while (a_ready !== 1'b0 && n < 6) begin step(); n++; end
      if (i == 0) begin
        chk("s4_drop_latency", 32'(n), 32'd2);
        cnt = 0; n = 0;
        while (a_pll_rst == 2'b11 && n < 20) begin cnt++; step(); n++; end
        chk("s4_pll_rst_len", 32'(cnt), 32'd4);
      end
      chk("s4_loss_cnt", 32'(a_loss), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      chk("s4_retry_cnt", 32'(a_retry), 32'd0);
      n = 0;
      while (a_ready !== 1'b1 && n < 40) begin step(); n++; end
      chk("s4_ready_again", 32'(a_ready), 32'd1);
    end
    chk("s4_loss_saturated", 32'(a_loss), 32'd255);
    chk("s4_masked_no_loss", 32'(b_loss), 32'd0);

    // RST during STABLE, then during FAIL
    lock = 2'b01; step(); lock = 2'b11;
    n = 0;
    while (a_state !== 3'd2 && n < 30) begin step(); n++; end
    chk("s6_reach_stable", 32'(a_state), 32'd2);
    rst = 1'b1; step();
    chk_reset_vals("s6_rst_in_stable");
    rst = 1'b0; lock = 2'b00;
    n = 0;
    while (a_fail !== 1'b1 && n < 200) begin step(); n++; end
    chk("s6_reach_fail", 32'(a_fail), 32'd1);
    rst = 1'b1; step();
    chk_reset_vals("s6_rst_in_fail");

    // PLL 1 masked out: its LOCK bit is ignored
    lock = 2'b01; step(); rst = 1'b0;
    n = 0;
    while (b_ready !== 1'b1 && n < 60) begin step(); n++; end
    chk("s5_mask_ready", 32'(b_ready), 32'd1);
    for (int i = 0; i < 60; i++) begin
      lock = {1'($urandom_range(0, 1)), 1'b1};
      step();
      chk("s5_mask_hold", 32'(b_ready), 32'd1);
    end

    // Randomised soak against the model
    for (int r = 0; r < 6; r++) begin
      rst = 1'b1; step(); step(); rst = 1'b0;
      seg = 0;
      for (int c = 0; c < 600; c++) begin
        if (seg == 0) begin
          n = int'($urandom_range(0, 9));
          if (n < 6)      lock = 2'b11;
          else if (n < 8) lock = 2'($urandom_range(0, 3));
          else            lock = 2'b00;
          seg = int'($urandom_range(1, 24));
        end
        seg--;
        retry_req = ($urandom_range(0, 15) == 0);
        rst       = ($urandom_range(0, 299) == 0);
        step();
      end
      retry_req = 1'b0;
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
